// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes consumed by alu_32 and the MIPS
// opcode/funct values the decode stage recognises.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/reg_file_32x32.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, R0 hardwired to zero, write-to-read bypass within the same cycle.
module reg_file_32x32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_data_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A write landing this cycle wins over the stored value so the reader
  // never captures a stale operand.
  always_comb begin
    if (rd_addr_a == 5'd0)                      rd_data_a = '0;
    else if (wr_en && (wr_addr == rd_addr_a))   rd_data_a = wr_data;
    else                                        rd_data_a = regs[rd_addr_a];

    if (rd_addr_b == 5'd0)                      rd_data_b = '0;
    else if (wr_en && (wr_addr == rd_addr_b))   rd_data_b = wr_data;
    else                                        rd_data_b = regs[rd_addr_b];
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage upstream of alu_32: reads operands, decodes the ALU control
// code and registers everything into a single valid/ready output slot.
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_alu_control,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_illegal
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic [31:0] rs_data, rt_data;
  logic [31:0] dec_b;
  logic [4:0]  dec_rd;
  logic [3:0]  dec_ctl;
  logic        dec_illegal, dec_reg_write;
  logic        accept;

  assign opcode = in_instr[31:26];
  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign imm    = in_instr[15:0];
  assign funct  = in_instr[5:0];

  reg_file_32x32 u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rs),
    .rd_data_a (rs_data),
    .rd_addr_b (rt),
    .rd_data_b (rt_data),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  always_comb begin
    dec_ctl     = ALU_AND;
    dec_illegal = 1'b0;
    dec_b       = rt_data;
    dec_rd      = in_instr[15:11];
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec_ctl = ALU_ADD;
          FN_SUB:  dec_ctl = ALU_SUB;
          FN_AND:  dec_ctl = ALU_AND;
          FN_OR:   dec_ctl = ALU_OR;
          FN_SLT:  dec_ctl = ALU_SLT;
          FN_NOR:  dec_ctl = ALU_NOR;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin dec_ctl = ALU_ADD; dec_b = sign_ext16(imm); dec_rd = rt; end
      OP_SLTI: begin dec_ctl = ALU_SLT; dec_b = sign_ext16(imm); dec_rd = rt; end
      OP_ANDI: begin dec_ctl = ALU_AND; dec_b = zero_ext16(imm); dec_rd = rt; end
      OP_ORI:  begin dec_ctl = ALU_OR;  dec_b = zero_ext16(imm); dec_rd = rt; end
      default: dec_illegal = 1'b1;
    endcase
    dec_reg_write = !dec_illegal && (dec_rd != 5'd0);
  end

  // Handshake: a transfer happens on a side when valid && ready at the rising
  // edge; the slot accepts when empty or being drained, and once out_valid is
  // high every output holds until out_ready is seen.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_a           <= '0;
      out_b           <= '0;
      out_alu_control <= ALU_AND;
      out_rd          <= '0;
      out_reg_write   <= 1'b0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_a           <= rs_data;
      out_b           <= dec_b;
      out_alu_control <= dec_ctl;
      out_rd          <= dec_rd;
      out_reg_write   <= dec_reg_write;
      out_illegal     <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode, immediates, bypass, stall,
// R0 handling, flush and asynchronous reset.
module tb_alu_decode_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [31:0] in_instr, wb_data, out_a, out_b;
  logic [4:0]  wb_addr, out_rd;
  logic [3:0]  out_alu_control;
  logic        out_reg_write, out_illegal;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  alu_decode_stage dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .flush           (flush),
    .wb_en           (wb_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_a           (out_a),
    .out_b           (out_b),
    .out_alu_control (out_alu_control),
    .out_rd          (out_rd),
    .out_reg_write   (out_reg_write),
    .out_illegal     (out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if ({out_a, out_b} !== 64'd0) begin errors++; $display("FAIL reset_ab got=%h/%h exp=0", out_a, out_b); end
    checks++; if ({out_alu_control, out_rd, out_reg_write, out_illegal} !== 11'd0) begin
      errors++; $display("FAIL reset_ctl got=%b/%d/%b/%b exp=0", out_alu_control, out_rd, out_reg_write, out_illegal); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_sub();
    wb_write(5'd1, 32'd200);
    wb_write(5'd2, 32'd150);
    in_valid = 1'b1; in_instr = rtype(5'd1, 5'd2, 5'd3, 6'b100010);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got=%b exp=1", out_valid); end
    checks++; if (out_a !== 32'd200 || out_b !== 32'd150) begin
      errors++; $display("FAIL sub_ops got=%0d/%0d exp=200/150", out_a, out_b); end
    checks++; if (out_alu_control !== 4'b0110 || out_rd !== 5'd3 || out_reg_write !== 1'b1) begin
      errors++; $display("FAIL sub_ctl got=%b/%0d/%b exp=0110/3/1", out_alu_control, out_rd, out_reg_write); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_immediates();
    in_valid = 1'b1; in_instr = itype(6'b001000, 5'd0, 5'd4, 16'hFFCE);
    tick();
    checks++; if (out_a !== 32'd0 || out_b !== 32'hFFFFFFCE || out_alu_control !== 4'b0010 || out_rd !== 5'd4) begin
      errors++; $display("FAIL addi got=%h/%h/%b/%0d exp=0/ffffffce/0010/4", out_a, out_b, out_alu_control, out_rd); end
    in_instr = itype(6'b001101, 5'd0, 5'd4, 16'hFFCE);
    tick();
    checks++; if (out_valid !== 1'b1 || out_b !== 32'h0000FFCE || out_alu_control !== 4'b0001) begin
      errors++; $display("FAIL ori got=%b/%h/%b exp=1/0000ffce/0001", out_valid, out_b, out_alu_control); end
    in_instr = itype(6'b001010, 5'd1, 5'd8, 16'h8000);
    tick();
    checks++; if (out_a !== 32'd200 || out_b !== 32'hFFFF8000 || out_alu_control !== 4'b0111 || out_rd !== 5'd8) begin
      errors++; $display("FAIL slti got=%h/%h/%b/%0d exp=c8/ffff8000/0111/8", out_a, out_b, out_alu_control, out_rd); end
    in_instr = itype(6'b001100, 5'd2, 5'd9, 16'h8001);
    tick();
    in_valid = 1'b0;
    checks++; if (out_b !== 32'h00008001 || out_alu_control !== 4'b0000 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL andi got=%h/%b/%b exp=00008001/0000/0", out_b, out_alu_control, out_illegal); end
    tick();
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAAAA5555;
    in_valid = 1'b1; in_instr = rtype(5'd5, 5'd5, 5'd6, 6'b100111);
    tick();
    wb_en = 1'b0;
    checks++; if (out_a !== 32'hAAAA5555 || out_b !== 32'hAAAA5555 || out_alu_control !== 4'b1100 || out_rd !== 5'd6) begin
      errors++; $display("FAIL bypass_nor got=%h/%h/%b/%0d exp=aaaa5555x2/1100/6", out_a, out_b, out_alu_control, out_rd); end
    in_instr = rtype(5'd5, 5'd0, 5'd8, 6'b100101);
    tick();
    in_valid = 1'b0;
    checks++; if (out_a !== 32'hAAAA5555 || out_b !== 32'd0 || out_alu_control !== 4'b0001) begin
      errors++; $display("FAIL bypass_commit got=%h/%h/%b exp=aaaa5555/0/0001", out_a, out_b, out_alu_control); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq_instr [4];
    logic        acc, cons;
    int          idx = 0;
    int          stall_cycles = 0;
    seq_instr[0] = rtype(5'd1, 5'd2, 5'd9,  6'b100000);
    seq_instr[1] = rtype(5'd1, 5'd2, 5'd10, 6'b100010);
    seq_instr[2] = rtype(5'd1, 5'd2, 5'd11, 6'b100100);
    seq_instr[3] = rtype(5'd1, 5'd2, 5'd12, 6'b101010);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = seq_instr[0];
    tick();
    exp_q.push_back(5'd9); idx = 1;
    checks++; if (out_a !== 32'd200 || out_rd !== 5'd9 || out_alu_control !== 4'b0010) begin
      errors++; $display("FAIL b2b_first got=%h/%0d/%b exp=c8/9/0010", out_a, out_rd, out_alu_control); end
    out_ready = 1'b0; in_instr = seq_instr[1];
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c < 3);
      in_valid = (idx < 4);
      if (idx < 4) in_instr = seq_instr[idx];
      #1;
      if (c < 3) begin
        stall_cycles++;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== 5'd9) begin
          errors++; $display("FAIL b2b_stall c=%0d got=%b/%b/%0d exp=0/1/9", c, in_ready, out_valid, out_rd); end
      end
      cons = out_valid && out_ready;
      acc  = in_valid && in_ready;
      if (cons) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_dup got=%0d exp=none", out_rd); end
        else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          if (out_rd !== e) begin errors++; $display("FAIL b2b_order got=%0d exp=%0d", out_rd, e); end
        end
      end
      if (acc) begin
        case (idx)
          1: exp_q.push_back(5'd10);
          2: exp_q.push_back(5'd11);
          default: exp_q.push_back(5'd12);
        endcase
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (exp_q.size() != 0 || idx != 4 || out_valid !== 1'b0 || stall_cycles != 3) begin
      errors++; $display("FAIL b2b_drain got=q%0d/i%0d/v%b exp=q0/i4/v0", exp_q.size(), idx, out_valid); end
  endtask

  task automatic test_r0();
    wb_write(5'd0, 32'hFFFFFFFF);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = rtype(5'd0, 5'd0, 5'd7, 6'b100000);
    tick();
    checks++; if (out_a !== 32'd0 || out_b !== 32'd0 || out_reg_write !== 1'b1) begin
      errors++; $display("FAIL r0_read got=%h/%h/%b exp=0/0/1", out_a, out_b, out_reg_write); end
    in_instr = rtype(5'd1, 5'd2, 5'd7, 6'b000000);
    tick();
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_alu_control !== 4'b0000) begin
      errors++; $display("FAIL illegal_funct got=%b/%b/%b/%b exp=1/1/0/0000", out_valid, out_illegal, out_reg_write, out_alu_control); end
    in_instr = itype(6'b100011, 5'd1, 5'd7, 16'h0004);
    tick();
    checks++; if (out_illegal !== 1'b1 || out_reg_write !== 1'b0) begin
      errors++; $display("FAIL illegal_op got=%b/%b exp=1/0", out_illegal, out_reg_write); end
    in_instr = rtype(5'd1, 5'd2, 5'd0, 6'b100000);
    tick();
    in_valid = 1'b0;
    checks++; if (out_illegal !== 1'b0 || out_reg_write !== 1'b0 || out_rd !== 5'd0) begin
      errors++; $display("FAIL rd_zero got=%b/%b/%0d exp=0/0/0", out_illegal, out_reg_write, out_rd); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
    tick();
    flush = 1'b1; in_instr = rtype(5'd1, 5'd2, 5'd4, 6'b100010);
    wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'h00001234;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    tick();
    flush = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_late got=%b exp=0", out_valid); end
    in_valid = 1'b1; in_instr = rtype(5'd11, 5'd0, 5'd12, 6'b100000);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_a !== 32'h00001234) begin
      errors++; $display("FAIL flush_wb got=%b/%h exp=1/00001234", out_valid, out_a); end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = rtype(5'd1, 5'd2, 5'd13, 6'b100101);
    tick();
    checks++; if (out_valid !== 1'b1 || out_a !== 32'd200) begin
      errors++; $display("FAIL pre_reset got=%b/%h exp=1/c8", out_valid, out_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_a !== 32'd0 || out_b !== 32'd0 || out_rd !== 5'd0 ||
                  out_alu_control !== 4'b0000 || out_reg_write !== 1'b0 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%b/%h/%h/%0d/%b/%b/%b exp=all0", out_valid, out_a, out_b,
                         out_rd, out_alu_control, out_reg_write, out_illegal); end
    tick();
    rst = 1'b0; out_ready = 1'b1;
    in_instr = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_a !== 32'd0 || out_b !== 32'd0) begin
      errors++; $display("FAIL regs_cleared got=%b/%h/%h exp=1/0/0", out_valid, out_a, out_b); end
    tick();
  endtask

  initial begin
    test_reset();
    test_sub();
    test_immediates();
    test_bypass();
    test_back_to_back();
    test_r0();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
